// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared scan sequencing types and MISR taps
package scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_WAIT,
        ST_DRAIN
    } scan_state_t;

    // Feedback taps on bits 31, 27, 2 and 1.
    localparam logic [31:0] MISR_TAPS = 32'h8800_0006;

    function automatic logic misr_feedback(input logic [31:0] sig, input logic din);
        return (^(sig & MISR_TAPS)) ^ din;
    endfunction

endpackage

// File: rtl/scan_pattern_sequencer_if.sv
// rtl/scan_pattern_sequencer_if.sv - pattern load handshake bundle
interface scan_pattern_sequencer_if #(
    parameter int CHAIN_LENGTH = 64
) ();
    logic                    pat_valid;
    logic                    pat_ready;
    logic [CHAIN_LENGTH-1:0] pat_stimulus;
    logic [CHAIN_LENGTH-1:0] pat_expect;
    logic [CHAIN_LENGTH-1:0] pat_mask;

    modport master (output pat_valid, pat_stimulus, pat_expect, pat_mask, input pat_ready);
    modport slave  (input pat_valid, pat_stimulus, pat_expect, pat_mask, output pat_ready);
endinterface

// File: rtl/scan_unload_checker.sv
// rtl/scan_unload_checker.sv - unload compare, fail counting and optional MISR
// Signature compression is built only when SCAN_SEQ_MISR_EN is defined.
module scan_unload_checker
    import scan_pkg::*;
#(
    parameter int CHAIN_LENGTH = 64,
    parameter int CNT_W        = 16
) (
    input  logic                            scan_clock,
    input  logic                            reset,
    input  logic                            cmp_valid,
    input  logic [$clog2(CHAIN_LENGTH)-1:0] bit_idx,
    input  logic                            scan_out,
    input  logic [CHAIN_LENGTH-1:0]         exp_cur,
    input  logic [CHAIN_LENGTH-1:0]         msk_cur,
    output logic [CNT_W-1:0]                fail_count,
    output logic [31:0]                     signature
);
    localparam int BW = $clog2(CHAIN_LENGTH);
    localparam logic [BW-1:0] LAST = BW'(CHAIN_LENGTH - 1);

    logic          pat_fail;
    logic [BW-1:0] pos;
    logic          mism;
    logic          last_edge;

    // The chain presents its MSB first, so edge k carries bit CHAIN_LENGTH-1-k.
    assign pos       = LAST - bit_idx;
    assign mism      = cmp_valid && msk_cur[pos] && (scan_out != exp_cur[pos]);
    assign last_edge = (bit_idx == LAST);

    always_ff @(posedge scan_clock or posedge reset) begin
        if (reset) begin
            pat_fail   <= 1'b0;
            fail_count <= '0;
        end else if (cmp_valid) begin
            if (last_edge) begin
                if ((pat_fail || mism) && (fail_count != '1))
                    fail_count <= fail_count + CNT_W'(1);
                pat_fail <= 1'b0;
            end else if (mism) begin
                pat_fail <= 1'b1;
            end
        end
    end

`ifdef SCAN_SEQ_MISR_EN
    logic [31:0] misr;

    always_ff @(posedge scan_clock or posedge reset) begin
        if (reset)
            misr <= '0;
        else if (cmp_valid)
            misr <= {misr[30:0], misr_feedback(misr, scan_out)};
    end

    assign signature = misr;
`else
    assign signature = 32'h0;
`endif

endmodule

// File: rtl/scan_pattern_sequencer.sv
// rtl/scan_pattern_sequencer.sv - scan chain load/capture/unload sequencer
// Optional signature MISR enabled by SCAN_SEQ_MISR_EN.
module scan_pattern_sequencer
    import scan_pkg::*;
#(
    parameter int CHAIN_LENGTH = 64,
    parameter int CNT_W        = 16
) (
    input  logic                     scan_clock,
    input  logic                     reset,
    scan_pattern_sequencer_if.slave  pat,
    input  logic                     flush,
    output logic                     scan_enable,
    output logic                     scan_in,
    output logic                     capture_enable,
    input  logic                     scan_out,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         pattern_count,
    output logic [CNT_W-1:0]         fail_count,
    output logic [31:0]              signature
);
    localparam int BW = $clog2(CHAIN_LENGTH);
    localparam logic [BW-1:0] LAST = BW'(CHAIN_LENGTH - 1);

    scan_state_t             state, next_state;
    logic [CHAIN_LENGTH-1:0] stim_sr, exp_nxt, msk_nxt, exp_cur, msk_cur;
    logic                    cmp_en;
    logic [BW-1:0]           bit_cnt;
    logic                    done_q;
    logic                    last_bit;
    logic                    cmp_valid;

    assign last_bit  = (bit_cnt == LAST);
    assign cmp_valid = ((state == ST_SHIFT) && cmp_en) || (state == ST_DRAIN);

    always_ff @(posedge scan_clock or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // A pending pattern in WAIT takes priority over flush.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (pat.pat_valid) next_state = ST_SHIFT;
            ST_SHIFT:   if (last_bit) next_state = ST_CAPTURE;
            ST_CAPTURE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (pat.pat_valid)
                    next_state = ST_SHIFT;
                else if (flush)
                    next_state = ST_DRAIN;
            end
            ST_DRAIN:   if (last_bit) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        pat.pat_ready  = (state == ST_IDLE) || (state == ST_WAIT);
        scan_enable    = (state == ST_SHIFT) || (state == ST_DRAIN);
        scan_in        = (state == ST_SHIFT) ? stim_sr[CHAIN_LENGTH-1] : 1'b0;
        capture_enable = (state == ST_CAPTURE);
        busy           = (state != ST_IDLE);
        done           = done_q;
    end

    always_ff @(posedge scan_clock or posedge reset) begin
        if (reset) begin
            stim_sr       <= '0;
            exp_nxt       <= '0;
            msk_nxt       <= '0;
            exp_cur       <= '0;
            msk_cur       <= '0;
            cmp_en        <= 1'b0;
            bit_cnt       <= '0;
            pattern_count <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (pat.pat_valid) begin
                        stim_sr <= pat.pat_stimulus;
                        exp_nxt <= pat.pat_expect;
                        msk_nxt <= pat.pat_mask;
                        cmp_en  <= (state == ST_WAIT);
                        bit_cnt <= '0;
                    end else if ((state == ST_WAIT) && flush) begin
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    stim_sr <= {stim_sr[CHAIN_LENGTH-2:0], 1'b0};
                    bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
                end
                ST_CAPTURE: begin
                    pattern_count <= pattern_count + CNT_W'(1);
                    exp_cur       <= exp_nxt;
                    msk_cur       <= msk_nxt;
                end
                ST_DRAIN: begin
                    bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
                    if (last_bit)
                        done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    scan_unload_checker #(
        .CHAIN_LENGTH (CHAIN_LENGTH),
        .CNT_W        (CNT_W)
    ) u_checker (
        .scan_clock (scan_clock),
        .reset      (reset),
        .cmp_valid  (cmp_valid),
        .bit_idx    (bit_cnt),
        .scan_out   (scan_out),
        .exp_cur    (exp_cur),
        .msk_cur    (msk_cur),
        .fail_count (fail_count),
        .signature  (signature)
    );

endmodule
